seq_shifter: RTL

SEQ_SHIFTER -- requirements
Module: seq_shifter

---
 rtl/seq_shifter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/seq_shifter.sv
// Sequential barrel-less shifter: one bit position per cycle for SLL/SRL/ROL/ROR/SRA.
// Define SEQ_SHIFTER_SRA_EN to build the arithmetic right shift; otherwise op 100 passes data through.
module seq_shifter #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SHW-1:0]   sh,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             busy
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // the producer holds its payload stable until then, and ready never depends on valid.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);
    localparam logic [SHW-1:0] CNT_ZERO = '0;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] step_val;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            work_q     <= '0;
            data_out_q <= '0;
            cnt_q      <= '0;
            op_q       <= '0;
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            data_out_q <= data_out_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
        end
    end

    // One-bit step of the latched operation; unknown codes leave the word unchanged.
    always_comb begin
        step_val = work_q;
        case (op_q)
            3'b000:  step_val = {work_q[WIDTH-2:0], 1'b0};
            3'b001:  step_val = {1'b0, work_q[WIDTH-1:1]};
            3'b010:  step_val = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
            3'b011:  step_val = {work_q[0], work_q[WIDTH-1:1]};
`ifdef SEQ_SHIFTER_SRA_EN
            3'b100:  step_val = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
`endif
            default: step_val = work_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = (sh != CNT_ZERO) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // data_out only moves when a result completes, so it holds the previous result while shifting.
    always_comb begin
        work_d     = work_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        data_out_d = data_out_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d = data_in;
                    cnt_d  = sh;
                    op_d   = op;
                    if (sh == CNT_ZERO) begin
                        data_out_d = data_in;
                    end
                end
            end
            SHIFT: begin
                work_d = step_val;
                cnt_d  = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    data_out_d = step_val;
                end
            end
            default: begin
                work_d = work_q;
            end
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        data_out  = data_out_q;
    end

endmodule
